add_sub_issuer: RTL

Issue/writeback controller for the packed add/sub unit of the mini core. It owns a 4-entry x 8-bit register file and accepts one instruction at a time over a valid/ready handshake. It drives operands and opcode into the packed add/sub unit, waits for that unit's done flag, and writes the result back. It is the initiator for the add/sub unit, sitting between instruction decode and the execution datapath.

---
 rtl/add_sub_issuer_if.sv | 56 +++++
 rtl/add_sub_issuer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/add_sub_issuer_if.sv
// add_sub_issuer_if: issue port, host regfile port, add/sub unit port and status.
// slave = issuer side, master = decode/host/unit side.
interface add_sub_issuer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_rs1;
  logic [1:0] instr_rs2;

  logic       ext_we;
  logic [1:0] ext_addr;
  logic [7:0] ext_data;
  logic [1:0] ext_raddr;
  logic [7:0] ext_rdata;

  logic [7:0] au_in1;
  logic [7:0] au_in2;
  logic [1:0] au_op;
  logic [7:0] au_out;
  logic       au_done;

  logic       res_valid;
  logic [1:0] res_rd;
  logic [7:0] res_data;

  logic       busy;
  logic       err_timeout;
  logic       err_illegal;

  modport slave (
    input  instr_valid, instr_op,
    input  instr_rd, instr_rs1, instr_rs2,
    output instr_ready,
    input  ext_we, ext_addr, ext_data,
    input  ext_raddr,
    output ext_rdata,
    output au_in1, au_in2, au_op,
    input  au_out, au_done,
    output res_valid, res_rd, res_data,
    output busy, err_timeout, err_illegal
  );

  modport master (
    output instr_valid, instr_op,
    output instr_rd, instr_rs1, instr_rs2,
    input  instr_ready,
    output ext_we, ext_addr, ext_data,
    output ext_raddr,
    input  ext_rdata,
    input  au_in1, au_in2, au_op,
    output au_out, au_done,
    input  res_valid, res_rd, res_data,
    input  busy, err_timeout, err_illegal
  );
endinterface

// File: rtl/add_sub_issuer.sv
// add_sub_issuer: issue/writeback controller for the packed add/sub unit.
// Ports: clk, rst (async active-low), io_if (slave: instr/ext/au/res/status).
module add_sub_issuer #(
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  add_sub_issuer_if.slave   io_if
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MOV = 2'd2;
  localparam logic [1:0] OP_ILL = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t        r_state;
  logic [7:0]    r_rf [4];
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_rd;
  logic [7:0]    r_in1;
  logic [7:0]    r_in2;
  logic [1:0]    r_op;
  logic          r_res_valid;
  logic [1:0]    r_res_rd;
  logic [7:0]    r_res_data;
  logic          r_err_to;
  logic          r_err_ill;

  logic          w_accept;
  logic          w_is_au;
  logic          w_is_mov;
  logic          w_is_ill;
  logic          w_to_hit;
  logic [7:0]    w_rs1_val;
  logic [7:0]    w_rs2_val;

  assign io_if.instr_ready = (r_state == IDLE);
  assign io_if.busy        = (r_state != IDLE);
  assign io_if.ext_rdata   = r_rf[io_if.ext_raddr];
  assign io_if.au_in1      = r_in1;
  assign io_if.au_in2      = r_in2;
  assign io_if.au_op       = r_op;
  assign io_if.res_valid   = r_res_valid;
  assign io_if.res_rd      = r_res_rd;
  assign io_if.res_data    = r_res_data;
  assign io_if.err_timeout = r_err_to;
  assign io_if.err_illegal = r_err_ill;

  assign w_accept  = io_if.instr_valid
                   & (r_state == IDLE);
  assign w_is_au   = (io_if.instr_op == OP_ADD)
                   | (io_if.instr_op == OP_SUB);
  assign w_is_mov  = (io_if.instr_op == OP_MOV);
  assign w_is_ill  = (io_if.instr_op == OP_ILL);

  // Pre-edge register values: an ext write in the
  // acceptance cycle lands after the operand capture.
  assign w_rs1_val = r_rf[io_if.instr_rs1];
  assign w_rs2_val = r_rf[io_if.instr_rs2];

  // Counter holds completed WAIT cycles minus one,
  // so hitting TIMEOUT-1 here means the TIMEOUT-th
  // idle WAIT cycle is ending.
  assign w_to_hit  = (r_cnt == CW'(TIMEOUT - 1));

  // Register file: ext write first, WB second, so the
  // writeback wins on an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        r_rf[i] <= 8'h00;
      end
    end else begin
      if (io_if.ext_we) begin
        r_rf[io_if.ext_addr] <= io_if.ext_data;
      end
      if (r_state == WB) begin
        r_rf[r_rd] <= r_res_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rd        <= 2'd0;
      r_in1       <= 8'h00;
      r_in2       <= 8'h00;
      r_op        <= 2'd0;
      r_res_valid <= 1'b0;
      r_res_rd    <= 2'd0;
      r_res_data  <= 8'h00;
      r_err_to    <= 1'b0;
      r_err_ill   <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      r_err_ill   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            unique case (1'b1)
              w_is_au: begin
                r_in1   <= w_rs1_val;
                r_in2   <= w_rs2_val;
                r_op    <= io_if.instr_op;
                r_rd    <= io_if.instr_rd;
                r_state <= ISSUE;
              end
              w_is_mov: begin
                r_rd        <= io_if.instr_rd;
                r_res_rd    <= io_if.instr_rd;
                r_res_data  <= w_rs1_val;
                r_res_valid <= 1'b1;
                r_state     <= WB;
              end
              w_is_ill: begin
                r_err_ill <= 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (io_if.au_done) begin
            r_res_data  <= io_if.au_out;
            r_res_rd    <= r_rd;
            r_res_valid <= 1'b1;
            r_state     <= WB;
          end else if (w_to_hit) begin
            r_err_to <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        WB: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
